sim_ctrl: RTL and testbench

- Synthesisable simulation/emulation controller for the vex_soc CDMA test harness.
- Replaces fixed-delay reset and fixed-time finish with:
  - a parametrised reset sequencer;
  - a kickable watchdog;
  - a CPU-visible pass/fail mailbox;
  - per-channel DMA completion tracking.
- Sits beside the SoC. The bench only waits on sim_done and reads the verdict.

---
 rtl/sim_ctrl_pkg.sv | 30 +++
 rtl/sim_ctrl_chtrack.sv | 62 ++++++
 rtl/sim_ctrl.sv | 175 +++++++++++++++++
 tb/tb_sim_ctrl.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation/emulation controller.
package sim_ctrl_pkg;

    // Controller phases. PASS, FAIL and TIMEOUT are terminal until reset.
    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    // Mailbox register map (write-only). Address 3 is reserved and ignored.
    localparam logic [1:0] ADDR_VERDICT = 2'd0;
    localparam logic [1:0] ADDR_KICK    = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;

    // Bit positions inside a VERDICT write.
    localparam int VERDICT_PASS_BIT = 0;
    localparam int VERDICT_FAIL_BIT = 1;

    // Failure codes generated by the controller itself.
    localparam logic [7:0] FAIL_TIMEOUT = 8'hFF;
    localparam logic [7:0] FAIL_CH_BASE = 8'h80;

    function automatic logic is_terminal(state_t s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/sim_ctrl_chtrack.sv
// Per-channel DMA completion tracker: sticky done/err flags, the channel
// mask, and the all-done / any-error / lowest-error-index summaries.
// Summaries include the current-cycle ch_done/ch_err so a decision can be
// taken on the same edge the event arrives.
module sim_ctrl_chtrack #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_err,
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_data,
    output logic              all_done,
    output logic              any_err,
    output logic [3:0]        err_idx
);

    logic [NUM_CH-1:0] done_sticky;
    logic [NUM_CH-1:0] err_sticky;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] done_now;
    logic [NUM_CH-1:0] err_masked;

    // Sticky flags accumulate only while sampling; mask follows CPU writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_sticky <= '0;
            err_sticky  <= '0;
            ch_mask     <= '1;
        end else begin
            // NOTE: every register uses <= so all flops see pre-edge values.
            if (sample) begin
                done_sticky <= done_sticky | ch_done;
                err_sticky  <= err_sticky | ch_err;
            end
            if (mask_we) begin
                ch_mask <= mask_data;
            end
        end
    end

    assign done_now   = done_sticky | ch_done;
    assign err_masked = (err_sticky | ch_err) & ch_mask;

    // An empty mask never counts as "all done": it disables auto-pass.
    assign all_done = (ch_mask != '0) && ((done_now & ch_mask) == ch_mask);
    assign any_err  = |err_masked;

    // Lowest-numbered masked channel reporting an error.
    always_comb begin
        // NOTE: default first so no path through the loop leaves err_idx unassigned (no latch).
        err_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (err_masked[i]) begin
                err_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sim_ctrl.sv
// Simulation controller for the CDMA test harness: sequences the SoC reset,
// runs a kickable watchdog, accepts a pass/fail verdict from the CPU and
// tracks DMA channel completion, ending in a sticky PASS/FAIL/TIMEOUT.
module sim_ctrl #(
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1400,
    parameter int NUM_CH         = 4,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              soc_reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [1:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_err,
    output logic              sim_done,
    output logic              sim_pass,
    output logic              sim_timeout,
    output logic [7:0]        fail_code,
    output logic [CNT_W-1:0]  cycle_count
);

    import sim_ctrl_pkg::*;

    localparam logic [7:0]       HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_RELOAD = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           next_state;
    logic [7:0]       hold_cnt;
    logic [CNT_W-1:0] wd;

    logic       in_hold;
    logic       in_run;
    logic       hold_last;
    logic       wr_fire;
    logic       verdict_we;
    logic       fail_req;
    logic       pass_req;
    logic       kick;
    logic       mask_we;
    logic       wd_expire;
    logic       all_done;
    logic       any_err;
    logic [3:0] err_idx;
    logic       unused_wr_data;

    assign in_hold   = (state == ST_HOLD);
    assign in_run    = (state == ST_RUN);
    assign hold_last = (hold_cnt == HOLD_LAST);

    // Mailbox decode; writes are only accepted in RUN.
    assign wr_fire    = wr_valid & wr_ready;
    assign verdict_we = wr_fire && (wr_addr == ADDR_VERDICT);
    assign fail_req   = verdict_we && wr_data[VERDICT_FAIL_BIT];
    assign pass_req   = verdict_we && wr_data[VERDICT_PASS_BIT];
    assign kick       = wr_fire && (wr_addr == ADDR_KICK);
    assign mask_we    = wr_fire && (wr_addr == ADDR_MASK);

    // A kick in the expiring cycle rescues the run.
    assign wd_expire = (wd == CNT_W'(1)) && !kick;

    // Only a slice of the write data is architecturally meaningful.
    assign unused_wr_data = ^wr_data;

    sim_ctrl_chtrack #(
        .NUM_CH(NUM_CH)
    ) u_chtrack (
        .clk      (clk),
        .reset    (reset),
        .sample   (in_run),
        .ch_done  (ch_done),
        .ch_err   (ch_err),
        .mask_we  (mask_we),
        .mask_data(wr_data[NUM_CH-1:0]),
        .all_done (all_done),
        .any_err  (any_err),
        .err_idx  (err_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_HOLD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; in RUN the outcomes rank fail > pass > timeout.
    always_comb begin
        next_state = state;
        case (state)
            ST_HOLD: begin
                if (hold_last) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fail_req || any_err) begin
                    next_state = ST_FAIL;
                end else if (pass_req || all_done) begin
                    next_state = ST_PASS;
                end else if (wd_expire) begin
                    next_state = ST_TIMEOUT;
                end
            end
            default: begin
                next_state = state;
            end
        endcase
    end

    // Reset-hold counter: RESET_CYCLES edges in HOLD before RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (in_hold && !hold_last) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // Watchdog: armed in HOLD, counts down in RUN, parked at 0 when the run ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd <= '0;
        end else if (in_hold) begin
            wd <= WD_RELOAD;
        end else if (in_run) begin
            if (next_state != ST_RUN) begin
                wd <= '0;
            end else if (kick) begin
                wd <= WD_RELOAD;
            end else begin
                wd <= wd - CNT_W'(1);
            end
        end
    end

    // RUN cycle counter, saturating; frozen once a terminal state is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (in_run && (cycle_count != '1)) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    // Failure code captured on the edge that enters FAIL or TIMEOUT. A CPU
    // fail verdict carries its own code and takes precedence over the
    // channel-derived one when both happen together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_code <= '0;
        end else if (in_run) begin
            if (next_state == ST_FAIL) begin
                fail_code <= fail_req ? wr_data[15:8] : (FAIL_CH_BASE | {4'b0000, err_idx});
            end else if (next_state == ST_TIMEOUT) begin
                fail_code <= FAIL_TIMEOUT;
            end
        end
    end

    // Outputs are pure decodes of the registered state.
    assign soc_reset   = in_hold;
    assign wr_ready    = in_run;
    assign sim_done    = is_terminal(state);
    assign sim_pass    = (state == ST_PASS);
    assign sim_timeout = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_sim_ctrl.sv
// Self-checking bench for sim_ctrl: directed scenarios plus randomized runs
// scored against a deadline/set-based model of the controller's rules.
module tb_sim_ctrl;

    localparam int RC  = 4;
    localparam int TO  = 20;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = 32;

    localparam logic [44:0] RST_VEC = {5'b10000, 8'h00, 32'h0};

    typedef struct packed {
        logic        valid;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [3:0]  done;
        logic [3:0]  err;
    } ev_t;

    localparam ev_t IDLE = '0;

    logic           clk;
    logic           reset;
    logic           soc_reset;
    logic           wr_valid;
    logic           wr_ready;
    logic [1:0]     wr_addr;
    logic [DW-1:0]  wr_data;
    logic [NCH-1:0] ch_done;
    logic [NCH-1:0] ch_err;
    logic           sim_done;
    logic           sim_pass;
    logic           sim_timeout;
    logic [7:0]     fail_code;
    logic [CW-1:0]  cycle_count;

    int checks = 0;
    int errors = 0;

    // Stimulus per RUN cycle: entry k-1 is applied during RUN cycle k.
    ev_t sched[$];

    sim_ctrl #(
        .RESET_CYCLES  (RC),
        .TIMEOUT_CYCLES(TO),
        .NUM_CH        (NCH),
        .DATA_W        (DW),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .soc_reset  (soc_reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ch_done    (ch_done),
        .ch_err     (ch_err),
        .sim_done   (sim_done),
        .sim_pass   (sim_pass),
        .sim_timeout(sim_timeout),
        .fail_code  (fail_code),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ev_t mk(logic v, logic [1:0] a, logic [31:0] d, logic [3:0] dn, logic [3:0] er);
        ev_t e;
        e.valid = v;
        e.addr  = a;
        e.data  = d;
        e.done  = dn;
        e.err   = er;
        return e;
    endfunction

    task automatic drive(input ev_t e);
        wr_valid = e.valid;
        wr_addr  = e.addr;
        wr_data  = e.data;
        ch_done  = e.done;
        ch_err   = e.err;
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic step(input ev_t e);
        drive(e);
        @(posedge clk);
        #1;
        drive(IDLE);
    endtask

    // Full reset plus HOLD; returns at the start of RUN cycle 1.
    task automatic apply_reset();
        reset = 1'b0;
        drive(IDLE);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (RC) @(posedge clk);
        #1;
    endtask

    // Plays sched (then idles) until sim_done, bounded by limit cycles.
    // end_k = RUN cycle whose edge produced sim_done, or -1 if never.
    // cc_errs counts RUN cycles where counter/handshake/soc_reset looked wrong.
    task automatic play(input int limit, output int end_k, output int cc_errs);
        end_k   = -1;
        cc_errs = 0;
        for (int k = 1; k <= limit; k++) begin
            step((k <= sched.size()) ? sched[k-1] : IDLE);
            if (sim_done === 1'b1) begin
                end_k = k;
                break;
            end
            if (cycle_count !== 32'(k) || wr_ready !== 1'b1 || soc_reset !== 1'b0) cc_errs++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference model. kind: 1 pass, 2 fail, 3 timeout. The watchdog is a
    // deadline: TO cycles after the last kick (cycle 0 at RUN entry).
    function automatic void predict(output int end_k, output int kind, output logic [7:0] code);
        logic [3:0] mask;
        logic [3:0] dn;
        logic [3:0] er;
        logic [3:0] hit;
        int deadline;
        mask     = 4'hF;
        dn       = '0;
        er       = '0;
        deadline = TO;
        end_k    = -1;
        kind     = 0;
        code     = 8'h00;
        for (int k = 1; k <= sched.size(); k++) begin
            ev_t  e;
            logic verdict;
            logic kick;
            e       = sched[k-1];
            verdict = e.valid && (e.addr == 2'd0);
            kick    = e.valid && (e.addr == 2'd1);
            dn      = dn | e.done;
            er      = er | e.err;
            hit     = er & mask;
            if ((verdict && e.data[1]) || (hit != 0)) begin
                end_k = k;
                kind  = 2;
                if (verdict && e.data[1]) begin
                    code = e.data[15:8];
                end else begin
                    for (int b = 3; b >= 0; b--) if (hit[b]) code = 8'h80 | 8'(b);
                end
                return;
            end
            if ((verdict && e.data[0]) || (mask != 0 && (dn & mask) == mask)) begin
                end_k = k;
                kind  = 1;
                return;
            end
            if (k == deadline && !kick) begin
                end_k = k;
                kind  = 3;
                code  = 8'hFF;
                return;
            end
            if (kick) deadline = k + TO;
            if (e.valid && e.addr == 2'd2) mask = e.data[3:0];
        end
        end_k = deadline;
        kind  = 3;
        code  = 8'hFF;
    endfunction

    task automatic test_reset();
        logic [44:0] got;
        reset = 1'b0;
        drive(IDLE);
        @(posedge clk);
        #1;
        got = {soc_reset, wr_ready, sim_done, sim_pass, sim_timeout, fail_code, cycle_count};
        checks++;
        if (got !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", got, RST_VEC);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= RC + 1; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({soc_reset, wr_ready} !== ((e < RC) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL reset_release edge=%0d soc_reset=%b wr_ready=%b", e, soc_reset, wr_ready);
            end
            if (e >= RC) begin
                checks++;
                if (cycle_count !== 32'(e - RC)) begin
                    errors++;
                    $display("FAIL cycle_count_start edge=%0d got=%0d exp=%0d", e, cycle_count, e - RC);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int end_k;
        int cc_errs;
        apply_reset();
        sched.delete();
        play(200, end_k, cc_errs);
        checks++;
        if (end_k != TO) begin
            errors++;
            $display("FAIL timeout_cycle got=%0d exp=%0d", end_k, TO);
        end
        checks++;
        if ({sim_done, sim_pass, sim_timeout, fail_code} !== {3'b101, 8'hFF}) begin
            errors++;
            $display("FAIL timeout_status got=%b%b%b code=%h exp=101 code=ff", sim_done, sim_pass, sim_timeout, fail_code);
        end
        checks++;
        if (cycle_count !== 32'(TO)) begin
            errors++;
            $display("FAIL timeout_count got=%0d exp=%0d", cycle_count, TO);
        end
        checks++;
        if ({wr_ready, soc_reset} !== 2'b00 || cc_errs != 0) begin
            errors++;
            $display("FAIL timeout_run got wr_ready=%b soc_reset=%b bad_cycles=%0d exp 0 0 0", wr_ready, soc_reset, cc_errs);
        end
    endtask

    task automatic test_kick();
        int end_k;
        int cc_errs;
        apply_reset();
        sched.delete();
        repeat (14) sched.push_back(IDLE);
        sched.push_back(mk(1'b1, 2'd1, 32'h0, 4'h0, 4'h0));
        play(200, end_k, cc_errs);
        checks++;
        if (end_k != 15 + TO) begin
            errors++;
            $display("FAIL kick_extend got=%0d exp=%0d", end_k, 15 + TO);
        end
        checks++;
        if ({sim_timeout, fail_code, cycle_count} !== {1'b1, 8'hFF, 32'(15 + TO)} || cc_errs != 0) begin
            errors++;
            $display("FAIL kick_status got to=%b code=%h cnt=%0d bad=%0d exp 1 ff %0d 0", sim_timeout, fail_code, cycle_count, cc_errs, 15 + TO);
        end
    endtask

    task automatic test_auto_pass();
        int end_k;
        int cc_errs;
        apply_reset();
        sched.delete();
        sched.push_back(mk(1'b1, 2'd2, 32'h0000_0005, 4'h0, 4'h0));
        repeat (3) sched.push_back(IDLE);
        sched.push_back(mk(1'b0, 2'd0, 32'h0, 4'b0001, 4'h0));
        sched.push_back(IDLE);
        sched.push_back(mk(1'b0, 2'd0, 32'h0, 4'b0000, 4'h0));
        sched.push_back(IDLE);
        sched.push_back(mk(1'b0, 2'd0, 32'h0, 4'b0100, 4'h0));
        play(200, end_k, cc_errs);
        checks++;
        if (end_k != 9) begin
            errors++;
            $display("FAIL auto_pass_cycle got=%0d exp=9", end_k);
        end
        checks++;
        if ({sim_done, sim_pass, sim_timeout, fail_code, cycle_count} !== {3'b110, 8'h00, 32'd9} || cc_errs != 0) begin
            errors++;
            $display("FAIL auto_pass_status got=%b%b%b code=%h cnt=%0d bad=%0d exp 110 00 9 0", sim_done, sim_pass, sim_timeout, fail_code, cycle_count, cc_errs);
        end
    endtask

    task automatic test_error_priority();
        int end_k;
        int cc_errs;
        apply_reset();
        sched.delete();
        repeat (2) sched.push_back(IDLE);
        sched.push_back(mk(1'b1, 2'd0, 32'h0000_0001, 4'h0, 4'b0100));
        play(200, end_k, cc_errs);
        checks++;
        if (end_k != 3) begin
            errors++;
            $display("FAIL err_priority_cycle got=%0d exp=3", end_k);
        end
        checks++;
        if ({sim_done, sim_pass, sim_timeout, fail_code} !== {3'b100, 8'h82}) begin
            errors++;
            $display("FAIL err_priority_status got=%b%b%b code=%h exp 100 code=82", sim_done, sim_pass, sim_timeout, fail_code);
        end
    endtask

    task automatic test_verdict_fail();
        int end_k;
        int cc_errs;
        apply_reset();
        sched.delete();
        repeat (3) sched.push_back(IDLE);
        sched.push_back(mk(1'b1, 2'd0, 32'h0000_2A03, 4'h0, 4'h0));
        play(200, end_k, cc_errs);
        checks++;
        if (end_k != 4) begin
            errors++;
            $display("FAIL verdict_fail_cycle got=%0d exp=4", end_k);
        end
        checks++;
        if ({sim_done, sim_pass, sim_timeout, fail_code, cycle_count} !== {3'b100, 8'h2A, 32'd4}) begin
            errors++;
            $display("FAIL verdict_fail_status got=%b%b%b code=%h cnt=%0d exp 100 2a 4", sim_done, sim_pass, sim_timeout, fail_code, cycle_count);
        end
    endtask

    task automatic test_mid_run_reset();
        int          end_k;
        int          cc_errs;
        logic [44:0] got;
        apply_reset();
        sched.delete();
        sched.push_back(mk(1'b0, 2'd0, 32'h0, 4'b0111, 4'h0));
        sched.push_back(mk(1'b1, 2'd0, 32'h0000_0001, 4'h0, 4'h0));
        play(200, end_k, cc_errs);
        checks++;
        if (end_k != 2 || sim_pass !== 1'b1) begin
            errors++;
            $display("FAIL midreset_prepass got end=%0d pass=%b exp end=2 pass=1", end_k, sim_pass);
        end
        #2;
        reset = 1'b0;
        #1;
        got = {soc_reset, wr_ready, sim_done, sim_pass, sim_timeout, fail_code, cycle_count};
        checks++;
        if (got !== RST_VEC) begin
            errors++;
            $display("FAIL midreset_async got=%h exp=%h", got, RST_VEC);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= RC; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (soc_reset !== ((e < RC) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL midreset_hold edge=%0d got=%b exp=%b", e, soc_reset, (e < RC));
            end
        end
        // Only channel 3 completes now; a lingering sticky 0..2 would auto-pass.
        sched.delete();
        sched.push_back(IDLE);
        sched.push_back(mk(1'b0, 2'd0, 32'h0, 4'b1000, 4'h0));
        play(200, end_k, cc_errs);
        checks++;
        if (end_k != TO || sim_timeout !== 1'b1 || sim_pass !== 1'b0) begin
            errors++;
            $display("FAIL midreset_sticky got end=%0d to=%b pass=%b exp end=%0d to=1 pass=0", end_k, sim_timeout, sim_pass, TO);
        end
    endtask

    task automatic test_random();
        int          end_k;
        int          cc_errs;
        int          exp_end;
        int          exp_kind;
        logic [7:0]  exp_code;
        logic [31:0] d;
        logic [1:0]  a;
        logic [3:0]  dn;
        logic [3:0]  er;
        for (int it = 0; it < 40; it++) begin
            apply_reset();
            sched.delete();
            for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
                a = 2'($urandom_range(0, 3));
                d = $urandom;
                if (a == 2'd0) d[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                for (int b = 0; b < 4; b++) begin
                    dn[b] = ($urandom_range(0, 7) == 0);
                    er[b] = ($urandom_range(0, 99) == 0);
                end
                sched.push_back(mk(($urandom_range(0, 9) < 3), a, d, dn, er));
            end
            predict(exp_end, exp_kind, exp_code);
            play(200, end_k, cc_errs);
            checks++;
            if (end_k != exp_end) begin
                errors++;
                $display("FAIL rand_end it=%0d got=%0d exp=%0d", it, end_k, exp_end);
            end
            checks++;
            if ({sim_done, sim_pass, sim_timeout} !== {1'b1, exp_kind == 1, exp_kind == 3}) begin
                errors++;
                $display("FAIL rand_kind it=%0d got=%b%b%b exp kind=%0d", it, sim_done, sim_pass, sim_timeout, exp_kind);
            end
            checks++;
            if (fail_code !== exp_code) begin
                errors++;
                $display("FAIL rand_code it=%0d got=%h exp=%h", it, fail_code, exp_code);
            end
            checks++;
            if (cycle_count !== 32'(exp_end) || cc_errs != 0) begin
                errors++;
                $display("FAIL rand_count it=%0d got=%0d bad=%0d exp=%0d bad=0", it, cycle_count, cc_errs, exp_end);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        drive(IDLE);
        test_reset();
        test_timeout();
        test_kick();
        test_auto_pass();
        test_error_priority();
        test_verdict_fail();
        test_mid_run_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
